// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write arbiter.
//   NUM_REGS   : architectural register count (register 0 is hardwired to zero)
//   ADDR_WIDTH : register index width
//   DATA_WIDTH : register data width
//   arbState_e : arbiter FSM states (ARB = serving requesters, CLEAR = zero-fill sweep)
//   ZERO_REG   : index of the hardwired-zero register
package regfile_pkg;

  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } arbState_e;

  localparam logic [ADDR_WIDTH-1:0] ZERO_REG  = 5'd0;
  localparam logic [ADDR_WIDTH-1:0] FIRST_REG = 5'd1;
  localparam logic [ADDR_WIDTH-1:0] LAST_REG  = ADDR_WIDTH'(NUM_REGS - 1);

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-requester grant logic for the register-file write port.
// Build option REGFILE_ARB_FAIR_EN:
//   defined   : round-robin, conflicts go to the requester not granted last
//   undefined : fixed priority, requester 0 always wins; no last-grant state
// Ports:
//   clock, ctrl_reset : clock and synchronous active-high reset
//   valid0, valid1    : requests
//   enable            : grants are being consumed this cycle (a transfer happens)
//   grant0, grant1    : combinational one-hot (or zero) grant
module rr_arbiter2 (
  input  logic clock,
  input  logic ctrl_reset,
  input  logic valid0,
  input  logic valid1,
  input  logic enable,
  output logic grant0,
  output logic grant1
);

`ifdef REGFILE_ARB_FAIR_EN
  // 1 means requester 1 was granted last; resets to 1 so requester 0 wins first.
  logic lastGrant;

  always_comb begin
    grant0 = valid0 && (!valid1 || lastGrant);
    grant1 = valid1 && (!valid0 || !lastGrant);
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      lastGrant <= 1'b1;
    end else if (enable && grant0) begin
      lastGrant <= 1'b0;
    end else if (enable && grant1) begin
      lastGrant <= 1'b1;
    end
  end
`else
  logic unusedInputs;
  assign unusedInputs = clock ^ ctrl_reset ^ enable;

  always_comb begin
    grant0 = valid0;
    grant1 = valid1 && !valid0;
  end
`endif

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the single write port of the 32x32 register file and shares it between
// requester 0 (ALU writeback) and requester 1 (multdiv/load writeback) using a
// valid/ready handshake. Also runs a zero-fill sweep of registers 1..31.
// Build option REGFILE_ARB_FAIR_EN selects round-robin (defined) or fixed
// priority to requester 0 (undefined) for conflicts.
// Ports:
//   clock, ctrl_reset          : clock, synchronous active-high reset
//   reqN_valid/reg/data        : requester N write request and payload
//   reqN_ready                 : requester N accepted this cycle (combinational)
//   clear_start                : one-cycle pulse to start the sweep
//   clear_busy                 : sweep writes are on the port
//   ctrl_writeEn/Reg, data_writeReg : registered regfile write port
module regfile_write_arbiter
  import regfile_pkg::*;
(
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_reg,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_reg,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  ctrl_writeEn,
  output logic [ADDR_WIDTH-1:0] ctrl_writeReg,
  output logic [DATA_WIDTH-1:0] data_writeReg
);

  arbState_e             stateQ;
  logic [ADDR_WIDTH-1:0] counterQ;
  logic                  arbEnable;
  logic                  grant0;
  logic                  grant1;

  assign arbEnable  = (stateQ == ARB) && !clear_start;
  assign req0_ready = arbEnable && grant0;
  assign req1_ready = arbEnable && grant1;

  rr_arbiter2 u_arbiter (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .enable     (arbEnable),
    .grant0     (grant0),
    .grant1     (grant1)
  );

  // The sweep's first write is issued on the clear_start edge itself, so the
  // 31 writes and clear_busy occupy exactly the same 31 cycles. The last write
  // is issued from CLEAR while the FSM already returns to ARB, letting a
  // requester be accepted back-to-back with the end of the sweep.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      stateQ        <= ARB;
      counterQ      <= FIRST_REG;
      clear_busy    <= 1'b0;
      ctrl_writeEn  <= 1'b0;
      ctrl_writeReg <= '0;
      data_writeReg <= '0;
    end else begin
      unique case (stateQ)
        ARB: begin
          clear_busy   <= 1'b0;
          ctrl_writeEn <= 1'b0;
          if (clear_start) begin
            stateQ        <= CLEAR;
            clear_busy    <= 1'b1;
            ctrl_writeEn  <= 1'b1;
            ctrl_writeReg <= counterQ;
            data_writeReg <= '0;
            counterQ      <= counterQ + 1'b1;
          end else if (req0_ready) begin
            // Writes to register 0 complete the handshake but never reach the port.
            if (req0_reg != ZERO_REG) begin
              ctrl_writeEn  <= 1'b1;
              ctrl_writeReg <= req0_reg;
              data_writeReg <= req0_data;
            end
          end else if (req1_ready) begin
            if (req1_reg != ZERO_REG) begin
              ctrl_writeEn  <= 1'b1;
              ctrl_writeReg <= req1_reg;
              data_writeReg <= req1_data;
            end
          end
        end
        CLEAR: begin
          clear_busy    <= 1'b1;
          ctrl_writeEn  <= 1'b1;
          ctrl_writeReg <= counterQ;
          data_writeReg <= '0;
          if (counterQ == LAST_REG) begin
            stateQ   <= ARB;
            counterQ <= FIRST_REG;
          end else begin
            counterQ <= counterQ + 1'b1;
          end
        end
        default: stateQ <= ARB;
      endcase
    end
  end

endmodule
